pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/y86_pkg.sv | 27 ++
 rtl/hazard_detect.sv | 31 +++
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 icode, status, register and control-state encodings
package y86_pkg;

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10,
    ST_FROZEN = 2'b11
  } ctrl_state_e;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational pipeline hazard and exception terms
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic       e_Cnd_i,
  input  logic [3:0] M_icode_i,
  input  logic [3:0] m_stat_i,
  input  logic [3:0] W_stat_i,
  output logic       load_use_o,
  output logic       ret_pend_o,
  output logic       mispred_o,
  output logic       m_exc_o,
  output logic       w_exc_o
);

  logic e_is_load;

  assign e_is_load  = (E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ);
  assign load_use_o = e_is_load && (E_dstM_i != RNONE) &&
                      ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign ret_pend_o = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
  assign mispred_o  = (E_icode_i == IJXX) && !e_Cnd_i;
  assign m_exc_o    = is_exc(m_stat_i);
  assign w_exc_o    = is_exc(W_stat_i);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble control, run/drain/halt FSM and perf counters
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic [1:0]       state,
  output logic [3:0]       halt_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic load_use, ret_pend, mispred, m_exc, w_exc;
  ctrl_state_e state_q, state_d, ctrl_state;
  logic [3:0] halt_stat_q, halt_stat_d;
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, mispred_cnt_q;
  logic active;

  hazard_detect u_hazard (
    .D_icode_i  (D_icode),
    .d_srcA_i   (d_srcA),
    .d_srcB_i   (d_srcB),
    .E_icode_i  (E_icode),
    .E_dstM_i   (E_dstM),
    .e_Cnd_i    (e_Cnd),
    .M_icode_i  (M_icode),
    .m_stat_i   (m_stat),
    .W_stat_i   (W_stat),
    .load_use_o (load_use),
    .ret_pend_o (ret_pend),
    .mispred_o  (mispred),
    .m_exc_o    (m_exc),
    .w_exc_o    (w_exc)
  );

  // Reset forces the RUN equations on the control outputs even while state_q is stale.
  assign ctrl_state = rst ? ST_RUN : state_q;

  always_comb begin
    F_stall  = load_use || ret_pend;
    D_stall  = load_use;
    D_bubble = mispred || (!load_use && ret_pend);
    E_bubble = mispred || load_use;
    M_bubble = m_exc || w_exc;
    W_stall  = w_exc;
    case (ctrl_state)
      ST_DRAIN: F_stall = 1'b1;
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b1;
      end
      ST_FROZEN: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    halt_stat_d = halt_stat_q;
    case (state_q)
      ST_RUN: begin
        if (m_exc)        state_d = ST_DRAIN;
        else if (!run_en) state_d = ST_FROZEN;
      end
      ST_FROZEN: if (run_en) state_d = ST_RUN;
      ST_DRAIN: begin
        if (w_exc) begin
          state_d     = ST_HALTED;
          halt_stat_d = W_stat;
        end
      end
      default: ;
    endcase
  end

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      halt_stat_q   <= SAOK;
      cycle_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_stat_q <= halt_stat_d;
      if (state_q != ST_HALTED) cycle_cnt_q   <= cycle_cnt_q + CNT_W'(1);
      if (active && F_stall)    stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
      if (active && mispred)    mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign halt_stat   = halt_stat_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
